// File: rtl/icache_refill_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl_pkg
// Shared types and default constants for the instruction-cache line refill
// controller.
//   refill_state_t        : controller state encoding
//   DEF_*                 : default parameter values used by icache_refill_ctrl
// -----------------------------------------------------------------------------
package icache_refill_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    BURST = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } refill_state_t;

  localparam int DEF_WORDS_PER_LINE = 16;
  localparam int DEF_MEM_WORD       = 32;
  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_TIMEOUT        = 64;

endpackage

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
// Refills one instruction-cache line after a miss. Requests a wrapping burst
// starting at the critical word, writes each returned beat into the data array,
// forwards the critical word early, and validates the tag when the line is full.
// A stalled burst is abandoned after TIMEOUT idle cycles.
//
// Ports
//   clk, nrst                      clock / synchronous active-low reset
//   miss_i, miss_addr_i            miss request and byte address from fetch
//   flush_i                        fetch redirect (suppresses early restart)
//   mem_req_o, mem_addr_o          burst request and critical-word address
//   mem_gnt_i                      request accepted by memory
//   mem_valid_i, mem_data_i        returned data beat
//   line_we_o, line_idx_o,
//   line_data_o                    data-array write port
//   tag_we_o                       tag validate pulse after a complete fill
//   crit_valid_o, crit_data_o      early-restart critical word
//   busy_o                         controller not idle
//   err_o                          beat timeout pulse
// -----------------------------------------------------------------------------
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int MEM_WORD       = DEF_MEM_WORD,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int TIMEOUT        = DEF_TIMEOUT,
  localparam int OFF_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                miss_i,
  input  logic [ADDR_W-1:0]   miss_addr_i,
  input  logic                flush_i,
  output logic                mem_req_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic                mem_gnt_i,
  input  logic                mem_valid_i,
  input  logic [MEM_WORD-1:0] mem_data_i,
  output logic                line_we_o,
  output logic [OFF_W-1:0]    line_idx_o,
  output logic [MEM_WORD-1:0] line_data_o,
  output logic                tag_we_o,
  output logic                crit_valid_o,
  output logic [MEM_WORD-1:0] crit_data_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int BO    = $clog2(MEM_WORD / 8);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  // Clears the byte offset within a memory word.
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'((MEM_WORD / 8) - 1);
  localparam logic [OFF_W-1:0]  LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  refill_state_t       state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [OFF_W-1:0]    crit_reg, crit_next;
  logic [OFF_W-1:0]    beat_cnt_reg, beat_cnt_next;
  logic [TMO_W-1:0]    tmo_cnt_reg, tmo_cnt_next;
  logic                suppress_reg, suppress_next;
  logic                line_we_reg, line_we_next;
  logic [OFF_W-1:0]    line_idx_reg, line_idx_next;
  logic [MEM_WORD-1:0] line_data_reg, line_data_next;
  logic                crit_valid_reg, crit_valid_next;
  logic [MEM_WORD-1:0] crit_data_reg, crit_data_next;
  logic                beat_fire;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      crit_reg       <= '0;
      beat_cnt_reg   <= '0;
      tmo_cnt_reg    <= '0;
      suppress_reg   <= 1'b0;
      line_we_reg    <= 1'b0;
      line_idx_reg   <= '0;
      line_data_reg  <= '0;
      crit_valid_reg <= 1'b0;
      crit_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      crit_reg       <= crit_next;
      beat_cnt_reg   <= beat_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      suppress_reg   <= suppress_next;
      line_we_reg    <= line_we_next;
      line_idx_reg   <= line_idx_next;
      line_data_reg  <= line_data_next;
      crit_valid_reg <= crit_valid_next;
      crit_data_reg  <= crit_data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    crit_next       = crit_reg;
    beat_cnt_next   = beat_cnt_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    suppress_next   = suppress_reg;
    line_we_next    = 1'b0;
    line_idx_next   = line_idx_reg;
    line_data_next  = line_data_reg;
    crit_valid_next = 1'b0;
    crit_data_next  = crit_data_reg;
    beat_fire       = 1'b0;

    case (state_reg)
      IDLE: begin
        // A redirect in the same cycle kills the miss.
        if (miss_i && !flush_i) begin
          addr_next     = miss_addr_i;
          crit_next     = miss_addr_i[BO+OFF_W-1:BO];
          beat_cnt_next = '0;
          tmo_cnt_next  = '0;
          suppress_next = 1'b0;
          state_next    = REQ;
        end
      end
      REQ: begin
        suppress_next = suppress_reg | flush_i;
        if (mem_gnt_i) begin
          state_next = BURST;
          // Memory may return beat 0 together with the grant.
          beat_fire  = mem_valid_i;
        end
      end
      BURST: begin
        suppress_next = suppress_reg | flush_i;
        if (mem_valid_i) begin
          beat_fire    = 1'b1;
          tmo_cnt_next = '0;
          if (beat_cnt_reg == LAST_BEAT) begin
            state_next = DONE;
          end
        end else if (tmo_cnt_reg == TMO_LAST) begin
          state_next = ERR;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (beat_fire) begin
      beat_cnt_next  = beat_cnt_reg + 1'b1;
      line_we_next   = 1'b1;
      // Wrap-order beats: index wraps naturally in OFF_W bits.
      line_idx_next  = crit_reg + beat_cnt_reg;
      line_data_next = mem_data_i;
      if (beat_cnt_reg == '0) begin
        crit_data_next = mem_data_i;
        // A redirect arriving with beat 0 also withholds the early restart.
        crit_valid_next = !suppress_reg && !flush_i;
      end
    end
  end

  assign mem_req_o    = (state_reg == REQ);
  assign mem_addr_o   = (state_reg == REQ) ? (addr_reg & WORD_MASK) : '0;
  assign line_we_o    = line_we_reg;
  assign line_idx_o   = line_idx_reg;
  assign line_data_o  = line_data_reg;
  assign tag_we_o     = (state_reg == DONE);
  assign crit_valid_o = crit_valid_reg;
  assign crit_data_o  = crit_data_reg;
  assign busy_o       = (state_reg != IDLE);
  assign err_o        = (state_reg == ERR);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_ctrl
// Directed self-checking bench for icache_refill_ctrl with N=16, MEM_WORD=32,
// ADDR_W=32, TIMEOUT=64.
// -----------------------------------------------------------------------------
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        miss_i;
  logic [31:0] miss_addr_i;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;
  logic        line_we_o;
  logic [3:0]  line_idx_o;
  logic [31:0] line_data_o;
  logic        tag_we_o;
  logic        crit_valid_o;
  logic [31:0] crit_data_o;
  logic        busy_o;
  logic        err_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Observed activity, sampled on the falling edge.
  int          wr_idx[$];
  logic [31:0] wr_data[$];
  int          crit_cnt;
  int          crit_pos;
  logic [31:0] crit_seen;
  int          tag_cnt;
  int          err_cnt;

  always #5 clk = ~clk;

  icache_refill_ctrl #(
    .WORDS_PER_LINE(16),
    .MEM_WORD(32),
    .ADDR_W(32),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .miss_i(miss_i),
    .miss_addr_i(miss_addr_i),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_valid_i(mem_valid_i),
    .mem_data_i(mem_data_i),
    .line_we_o(line_we_o),
    .line_idx_o(line_idx_o),
    .line_data_o(line_data_o),
    .tag_we_o(tag_we_o),
    .crit_valid_o(crit_valid_o),
    .crit_data_o(crit_data_o),
    .busy_o(busy_o),
    .err_o(err_o)
  );

  always @(negedge clk) begin
    if (line_we_o) begin
      wr_idx.push_back(int'(line_idx_o));
      wr_data.push_back(line_data_o);
    end
    if (crit_valid_o) begin
      crit_cnt++;
      crit_pos  = wr_idx.size();
      crit_seen = crit_data_o;
    end
    if (tag_we_o) tag_cnt++;
    if (err_o) err_cnt++;
  end

  // Content of line word w as served by the memory model.
  function automatic logic [31:0] word(input int w);
    return 32'hC0DE_0100 + 32'(w);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_idx.delete();
    wr_data.delete();
    crit_cnt  = 0;
    crit_pos  = 0;
    crit_seen = '0;
    tag_cnt   = 0;
    err_cnt   = 0;
  endtask

  // Returns one cycle after the miss is taken (controller in REQ).
  task automatic issue_miss(input logic [31:0] addr);
    miss_i      = 1'b1;
    miss_addr_i = addr;
    @(posedge clk); #1;
    miss_i      = 1'b0;
    miss_addr_i = 32'hFFFF_FFFF;
  endtask

  task automatic run_burst(input logic [31:0] exp_addr, input int crit, input int gnt_dly,
                           input int gap, input int nbeats, input bit same_cycle,
                           input bit junk_req, input bit miss_during);
    for (int i = 0; i < gnt_dly; i++) begin
      check("req_hold", mem_req_o, 1);
      check("req_addr", mem_addr_o, exp_addr);
      if (junk_req) begin
        mem_valid_i = 1'b1;
        mem_data_i  = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
    end
    check("req_hold", mem_req_o, 1);
    check("req_addr", mem_addr_o, exp_addr);
    mem_gnt_i = 1'b1;
    if (same_cycle) begin
      mem_valid_i = 1'b1;
      mem_data_i  = word(crit);
    end else begin
      mem_valid_i = 1'b0;
    end
    @(posedge clk); #1;
    mem_gnt_i   = 1'b0;
    mem_valid_i = 1'b0;
    check("req_drop", mem_req_o, 0);
    for (int k = (same_cycle ? 1 : 0); k < nbeats; k++) begin
      for (int g = 1; g < gap; g++) begin
        if (miss_during && k == 2) begin
          miss_i      = 1'b1;
          miss_addr_i = 32'h0000_0300;
        end
        @(posedge clk); #1;
        if (miss_during && k == 2) begin
          miss_i = 1'b0;
          check("burst_miss_noreq", mem_req_o, 0);
          check("burst_miss_busy", busy_o, 1);
        end
      end
      mem_valid_i = 1'b1;
      mem_data_i  = word((crit + k) % 16);
      @(posedge clk); #1;
      mem_valid_i = 1'b0;
    end
  endtask

  // Called right after the last beat was accepted (controller in DONE).
  task automatic finish_fill(input int crit, input bit exp_crit);
    check("tag_pulse", tag_we_o, 1);
    check("done_busy", busy_o, 1);
    @(posedge clk); #1;
    check("tag_single", tag_we_o, 0);
    check("idle_busy", busy_o, 0);
    check("wr_count", wr_idx.size(), 16);
    for (int k = 0; k < wr_idx.size(); k++) begin
      check($sformatf("wr_idx[%0d]", k), wr_idx[k], (crit + k) % 16);
      check($sformatf("wr_data[%0d]", k), wr_data[k], word((crit + k) % 16));
    end
    check("tag_cnt", tag_cnt, 1);
    if (exp_crit) begin
      check("crit_cnt", crit_cnt, 1);
      check("crit_with_beat0", crit_pos, 1);
      check("crit_data", crit_seen, word(crit));
    end else begin
      check("crit_suppressed", crit_cnt, 0);
    end
  endtask

  initial begin
    int n;
    nrst        = 1'b0;
    miss_i      = 1'b0;
    miss_addr_i = '0;
    flush_i     = 1'b0;
    mem_gnt_i   = 1'b0;
    mem_valid_i = 1'b0;
    mem_data_i  = '0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_req", mem_req_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_we", line_we_o, 0);
    check("rst_tag", tag_we_o, 0);
    check("rst_crit", crit_valid_o, 0);
    check("rst_err", err_o, 0);
    nrst = 1'b1;
    @(posedge clk); #1;
    $display("step: reset state checked");

    // Miss with simultaneous flush in IDLE is dropped.
    miss_i = 1'b1; flush_i = 1'b1; miss_addr_i = 32'h124;
    @(posedge clk); #1;
    miss_i = 1'b0; flush_i = 1'b0;
    check("flushmiss_busy", busy_o, 0);
    check("flushmiss_req", mem_req_o, 0);
    // Data beat while idle is ignored.
    mem_valid_i = 1'b1; mem_data_i = 32'h1234_5678;
    @(posedge clk); #1;
    mem_valid_i = 1'b0;
    check("idle_beat_we", line_we_o, 0);
    $display("step: idle flush priority / idle beat ignored");

    // Miss 0x124: crit 9, grant after 2 cycles, beat every 2nd cycle.
    clear_mon();
    issue_miss(32'h124);
    run_burst(32'h124, 9, 2, 2, 16, 1'b0, 1'b0, 1'b0);
    finish_fill(9, 1'b1);
    $display("step: miss 0x124 crit=9 writes=%0d", wr_idx.size());

    // Miss 0x13C: crit 15, junk valid before grant, beat 0 with grant, back-to-back.
    clear_mon();
    issue_miss(32'h13C);
    run_burst(32'h13C, 15, 1, 1, 16, 1'b1, 1'b1, 1'b0);
    finish_fill(15, 1'b1);
    $display("step: miss 0x13C crit=15 writes=%0d", wr_idx.size());

    // Flush one cycle after the miss, before grant: no early restart.
    clear_mon();
    issue_miss(32'h124);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    run_burst(32'h124, 9, 1, 2, 16, 1'b0, 1'b0, 1'b0);
    finish_fill(9, 1'b0);
    $display("step: flushed fill writes=%0d crit=%0d", wr_idx.size(), crit_cnt);

    // Beats stop after beat 5: timeout.
    clear_mon();
    issue_miss(32'h100);
    run_burst(32'h100, 0, 0, 1, 6, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!err_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("tmo_cycles", n, 64);
    check("tmo_err", err_o, 1);
    check("tmo_no_tag", tag_we_o, 0);
    @(posedge clk); #1;
    check("tmo_busy_after", busy_o, 0);
    check("tmo_err_single", err_o, 0);
    check("tmo_err_cnt", err_cnt, 1);
    check("tmo_tag_cnt", tag_cnt, 0);
    check("tmo_writes", wr_idx.size(), 6);
    $display("step: timeout after %0d idle cycles", n);

    // Reset after beat 3, then a fresh miss at 0x200.
    clear_mon();
    issue_miss(32'h124);
    run_burst(32'h124, 9, 1, 2, 4, 1'b0, 1'b0, 1'b0);
    nrst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_req", mem_req_o, 0);
    check("mid_rst_addr", mem_addr_o, 0);
    check("mid_rst_we", line_we_o, 0);
    check("mid_rst_idx", line_idx_o, 0);
    check("mid_rst_data", line_data_o, 0);
    check("mid_rst_tag", tag_we_o, 0);
    check("mid_rst_crit", crit_valid_o, 0);
    check("mid_rst_critd", crit_data_o, 0);
    check("mid_rst_err", err_o, 0);
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_no_tag", tag_cnt, 0);
    clear_mon();
    issue_miss(32'h200);
    run_burst(32'h200, 0, 1, 2, 16, 1'b0, 1'b0, 1'b0);
    finish_fill(0, 1'b1);
    $display("step: reset mid-burst, refill 0x200 writes=%0d", wr_idx.size());

    // Second miss during BURST is ignored, not queued.
    clear_mon();
    issue_miss(32'h124);
    run_burst(32'h124, 9, 1, 2, 16, 1'b0, 1'b0, 1'b1);
    finish_fill(9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_queued_req", mem_req_o, 0);
      check("no_queued_busy", busy_o, 0);
    end
    clear_mon();
    issue_miss(32'h300);
    run_burst(32'h300, 0, 0, 1, 16, 1'b0, 1'b0, 1'b0);
    finish_fill(0, 1'b1);
    $display("step: miss in burst ignored, new miss 0x300 writes=%0d", wr_idx.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
